if_fetch_stage: RTL and testbench
=================================

// Module: if_fetch_stage
// PURPOSE
//  Instruction-fetch stage of the 8-bit pipeline; the producer of the PC/inst/stall triple consumed by ID.
//  Owns the program counter and runs a req/ack handshake to instruction memory with any number of wait states.
//  Presents one registered instruction per cycle to ID and honours a hold from the hazard logic.
//  Applies jump redirects from the later stage, including discarding a fetch already in flight.
// PARAMETERS
//  RESET_PC   8'h00  value loaded into the fetch PC on reset
// PORTS
//  clock       in   1  single clock, rising edge
//  resetn      in   1  reset, asynchronous, active-low
//  hold        in   1  1 = freeze outputs to ID (load-use/structural stall)
//  J           in   1  1 = redirect fetch to jumpTarget this cycle
//  jumpTarget  in   8  redirect address
//  imem_req    out  1  fetch request to instruction memory
//  imem_addr   out  8  fetch address; stable while imem_req=1 and imem_ack=0
//  imem_ack    in   1  imem_data valid for imem_addr this cycle
//  imem_data   in   8  instruction byte from memory
//  PC          out  8  address of the instruction on inst
//  inst        out  8  instruction to ID
//  stall       out  1  ID enable: 1 = inst valid, decode it; 0 = bubble (ID zeroes control)
// BEHAVIOUR
//  Reset (async, resetn=0): pc_q=RESET_PC, state=FETCH, imem_req=0, PC=8'h00, inst=8'h00, stall=0.
//   Buffer and redirect registers are cleared. imem_req rises on the first edge after resetn releases.
//   A reset mid-handshake abandons the transfer; memory must tolerate the dropped req.
//  pc_q is 8-bit and increments modulo 256 (8'hFF -> 8'h00); the wrap is not flagged.
//  States:
//   FETCH:
//    imem_req=1, imem_addr=pc_q.
//    Edge with J=1 (any ack, any hold): if ack=1, drop the data; pc_q<=jumpTarget, stay in FETCH.
//     If ack=0, redir_q<=jumpTarget and go to KILL. In both cases stall<=0.
//    Edge with ack=1, J=0, hold=0: inst<=imem_data, PC<=pc_q, stall<=1, pc_q<=pc_q+1.
//    Edge with ack=1, J=0, hold=1: buf_q<=imem_data, bufpc_q<=pc_q, go to HELD. Outputs unchanged.
//    Edge with ack=0, J=0: if hold=0, stall<=0 (bubble); if hold=1, outputs unchanged.
//   KILL:
//    imem_req=1 with the old address until ack; the returned data is discarded. stall=0 throughout.
//    Edge with ack=1: pc_q<=redir_q (or jumpTarget if J=1 again this edge), go to FETCH.
//    Edge with J=1 and ack=0: redir_q<=jumpTarget (the last jump wins).
//   HELD:
//    imem_req=0.
//    Edge with J=1: drop the buffer, pc_q<=jumpTarget, stall<=0, go to FETCH.
//    Edge with hold=0, J=0: inst<=buf_q, PC<=bufpc_q, stall<=1, pc_q<=bufpc_q+1, go to FETCH.
//  Priority: reset > J > hold > normal advance. J always injects a bubble, even when hold=1.
//  Latency: with hold=0, J=0 and a zero-wait memory (ack in the same cycle as req), one instruction per cycle.
//   inst appears 1 edge after ack. Each wait state inserts exactly one bubble.
//  While hold=1 and J=0, PC, inst and stall never change.
//   At most one instruction is fetched ahead, so a fetch is never lost and never duplicated.
//  imem_addr is combinational from pc_q, so there are no glitches across ack edges.
// TESTING
//  1. Reset with RESET_PC=8'h10, zero-wait memory returning data=addr^8'hA5.
//     -> After release: inst=8'hB5 at PC=8'h10, then 8'hB4 at PC=8'h11; stall=1 every cycle.
//  2. Memory with 2 wait states.
//     -> Exactly 2 cycles of stall=0 between valid instructions; PC steps by +1.
//  3. Assert hold for 3 cycles while a fetch acks mid-hold.
//     -> PC/inst frozen; imem_req=0 after capture; on release the buffered instruction appears next; no skip, no repeat.
//  4. J=1 with jumpTarget=8'h40 while a fetch of 8'h05 waits for ack.
//     -> req stays on 8'h05 until ack; that data is discarded; the next request is 8'h40; stall=0 until inst@8'h40.
//  5. pc_q=8'hFF, zero-wait memory.
//     -> PC=8'hFF is followed by PC=8'h00.
//  6. J and hold asserted together in HELD; separately, resetn pulsed mid-wait.
//     -> J wins: buffer dropped, fetch from the target. Reset: outputs return to zero immediately and fetch restarts at RESET_PC.

Source files
------------

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC, runs a req/ack handshake to instruction memory
// and hands one registered PC/inst/stall triple per cycle to decode.
module if_fetch_stage #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       hold,
  input  logic       J,
  input  logic [7:0] jumpTarget,
  output logic       imem_req,
  output logic [7:0] imem_addr,
  input  logic       imem_ack,
  input  logic [7:0] imem_data,
  output logic [7:0] PC,
  output logic [7:0] inst,
  output logic       stall
);

  typedef enum logic [1:0] {
    StFetch,
    StKill,
    StHeld
  } state_e;

  state_e     state_q, state_d;
  logic       active_q, active_d;
  logic [7:0] pc_q, pc_d;
  logic [7:0] redir_q, redir_d;
  logic [7:0] buf_q, buf_d;
  logic [7:0] bufpc_q, bufpc_d;
  logic [7:0] pc_out_q, pc_out_d;
  logic [7:0] inst_q, inst_d;
  logic       stall_q, stall_d;

  // State register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= StFetch;
      active_q <= 1'b0;
      pc_q     <= RESET_PC;
      redir_q  <= 8'h00;
      buf_q    <= 8'h00;
      bufpc_q  <= 8'h00;
      pc_out_q <= 8'h00;
      inst_q   <= 8'h00;
      stall_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
      pc_q     <= pc_d;
      redir_q  <= redir_d;
      buf_q    <= buf_d;
      bufpc_q  <= bufpc_d;
      pc_out_q <= pc_out_d;
      inst_q   <= inst_d;
      stall_q  <= stall_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    pc_d     = pc_q;
    redir_d  = redir_q;
    buf_d    = buf_q;
    bufpc_d  = bufpc_q;
    pc_out_d = pc_out_q;
    inst_d   = inst_q;
    stall_d  = stall_q;

    case (state_q)
      StFetch: begin
        if (!active_q) begin
          // First edge after reset only raises req; no transfer is outstanding yet.
          active_d = 1'b1;
          if (J) begin
            pc_d = jumpTarget;
          end
        end else if (J) begin
          stall_d = 1'b0;
          if (imem_ack) begin
            pc_d = jumpTarget;
          end else begin
            redir_d = jumpTarget;
            state_d = StKill;
          end
        end else if (imem_ack) begin
          if (hold) begin
            buf_d   = imem_data;
            bufpc_d = pc_q;
            state_d = StHeld;
          end else begin
            inst_d   = imem_data;
            pc_out_d = pc_q;
            stall_d  = 1'b1;
            pc_d     = pc_q + 8'd1;
          end
        end else if (!hold) begin
          stall_d = 1'b0;
        end
      end

      StKill: begin
        // Wait out the in-flight fetch, then discard its data.
        stall_d = 1'b0;
        if (imem_ack) begin
          pc_d    = J ? jumpTarget : redir_q;
          state_d = StFetch;
        end else if (J) begin
          redir_d = jumpTarget;
        end
      end

      StHeld: begin
        if (J) begin
          buf_d   = 8'h00;
          pc_d    = jumpTarget;
          stall_d = 1'b0;
          state_d = StFetch;
        end else if (!hold) begin
          inst_d   = buf_q;
          pc_out_d = bufpc_q;
          stall_d  = 1'b1;
          pc_d     = bufpc_q + 8'd1;
          state_d  = StFetch;
        end
      end

      default: begin
        state_d = StFetch;
      end
    endcase
  end

  // Outputs
  always_comb begin
    imem_req  = active_q && (state_q != StHeld);
    imem_addr = pc_q;
    PC        = pc_out_q;
    inst      = inst_q;
    stall     = stall_q;
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage against a memory model returning addr^8'hA5 with
// a programmable number of wait states.
module tb_if_fetch_stage;

  logic       clock;
  logic       resetn;
  logic       hold;
  logic       J;
  logic [7:0] jumpTarget;
  logic       imem_req;
  logic [7:0] imem_addr;
  logic       imem_ack;
  logic [7:0] imem_data;
  logic [7:0] PC;
  logic [7:0] inst;
  logic       stall;

  logic [1:0] wait_n;
  logic [1:0] wcnt;
  int         n_pass;
  int         n_fail;
  int         n_total;

  if_fetch_stage #(
    .RESET_PC(8'h10)
  ) dut (
    .clock     (clock),
    .resetn    (resetn),
    .hold      (hold),
    .J         (J),
    .jumpTarget(jumpTarget),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_ack  (imem_ack),
    .imem_data (imem_data),
    .PC        (PC),
    .inst      (inst),
    .stall     (stall)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory model: acks after wait_n cycles of continuous request.
  assign imem_ack  = imem_req && (wcnt == wait_n);
  assign imem_data = imem_addr ^ 8'hA5;

  always @(posedge clock or negedge resetn) begin
    if (!resetn) wcnt <= 2'd0;
    else if (!imem_req || imem_ack) wcnt <= 2'd0;
    else wcnt <= wcnt + 2'd1;
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    n_pass = 0; n_fail = 0; n_total = 0;
    resetn = 1'b0; hold = 1'b0; J = 1'b0; jumpTarget = 8'h00; wait_n = 2'd0;

    // Reset state
    step();
    check("rst_req", {7'd0, imem_req}, 8'h00);
    check("rst_pc", PC, 8'h00);
    check("rst_inst", inst, 8'h00);
    check("rst_stall", {7'd0, stall}, 8'h00);
    resetn = 1'b1;

    // Zero-wait stream from RESET_PC
    step();
    check("t1_req", {7'd0, imem_req}, 8'h01);
    check("t1_addr", imem_addr, 8'h10);
    check("t1_stall0", {7'd0, stall}, 8'h00);
    step();
    check("t1_pc0", PC, 8'h10);
    check("t1_inst0", inst, 8'hB5);
    check("t1_stall1", {7'd0, stall}, 8'h01);
    step();
    check("t1_pc1", PC, 8'h11);
    check("t1_inst1", inst, 8'hB4);
    check("t1_stall2", {7'd0, stall}, 8'h01);

    // Two wait states: two bubbles per instruction
    wait_n = 2'd2;
    step(); check("t2_bub0", {7'd0, stall}, 8'h00);
    step(); check("t2_bub1", {7'd0, stall}, 8'h00);
    step();
    check("t2_pc0", PC, 8'h12);
    check("t2_inst0", inst, 8'hB7);
    check("t2_v0", {7'd0, stall}, 8'h01);
    step(); check("t2_bub2", {7'd0, stall}, 8'h00);
    step(); check("t2_bub3", {7'd0, stall}, 8'h00);
    step();
    check("t2_pc1", PC, 8'h13);
    check("t2_inst1", inst, 8'hB6);

    // Hold for three cycles, fetch acks mid-hold
    wait_n = 2'd1; hold = 1'b1;
    step();
    check("t3_frz_pc0", PC, 8'h13);
    check("t3_frz_st0", {7'd0, stall}, 8'h01);
    check("t3_req0", {7'd0, imem_req}, 8'h01);
    step();
    check("t3_frz_pc1", PC, 8'h13);
    check("t3_frz_inst1", inst, 8'hB6);
    check("t3_req1", {7'd0, imem_req}, 8'h00);
    step();
    check("t3_frz_pc2", PC, 8'h13);
    check("t3_req2", {7'd0, imem_req}, 8'h00);
    hold = 1'b0;
    step();
    check("t3_rel_pc", PC, 8'h14);
    check("t3_rel_inst", inst, 8'hB1);
    check("t3_rel_stall", {7'd0, stall}, 8'h01);
    check("t3_rel_addr", imem_addr, 8'h15);
    wait_n = 2'd0;
    step();
    check("t3_next_pc", PC, 8'h15);
    check("t3_next_inst", inst, 8'hB0);

    // Jump while a fetch of 8'h05 waits
    J = 1'b1; jumpTarget = 8'h05;
    step();
    check("t4_j05_stall", {7'd0, stall}, 8'h00);
    check("t4_j05_addr", imem_addr, 8'h05);
    wait_n = 2'd3; jumpTarget = 8'h40;
    step();
    J = 1'b0;
    check("t4_kill_addr0", imem_addr, 8'h05);
    check("t4_kill_st0", {7'd0, stall}, 8'h00);
    step();
    check("t4_kill_addr1", imem_addr, 8'h05);
    step();
    check("t4_kill_addr2", imem_addr, 8'h05);
    check("t4_kill_ack", {7'd0, imem_ack}, 8'h01);
    check("t4_kill_st2", {7'd0, stall}, 8'h00);
    step();
    check("t4_redir_addr", imem_addr, 8'h40);
    check("t4_redir_st", {7'd0, stall}, 8'h00);
    wait_n = 2'd0;
    step();
    check("t4_tgt_pc", PC, 8'h40);
    check("t4_tgt_inst", inst, 8'hE5);
    check("t4_tgt_st", {7'd0, stall}, 8'h01);

    // PC wrap 8'hFF -> 8'h00
    J = 1'b1; jumpTarget = 8'hFF;
    step();
    J = 1'b0;
    step();
    check("t5_pc_ff", PC, 8'hFF);
    check("t5_inst_ff", inst, 8'h5A);
    step();
    check("t5_pc_00", PC, 8'h00);
    check("t5_inst_00", inst, 8'hA5);

    // J and hold together while HELD
    hold = 1'b1;
    step();
    check("t6_held_req", {7'd0, imem_req}, 8'h00);
    check("t6_held_pc", PC, 8'h00);
    J = 1'b1; jumpTarget = 8'h80;
    step();
    J = 1'b0; hold = 1'b0;
    check("t6_j_stall", {7'd0, stall}, 8'h00);
    check("t6_j_req", {7'd0, imem_req}, 8'h01);
    check("t6_j_addr", imem_addr, 8'h80);
    step();
    check("t6_j_pc", PC, 8'h80);
    check("t6_j_inst", inst, 8'h25);

    // Reset pulsed mid-wait
    wait_n = 2'd2;
    step();
    check("t6_wait_stall", {7'd0, stall}, 8'h00);
    #1 resetn = 1'b0;
    #1;
    check("t6_rst_pc", PC, 8'h00);
    check("t6_rst_inst", inst, 8'h00);
    check("t6_rst_req", {7'd0, imem_req}, 8'h00);
    #1 resetn = 1'b1;
    wait_n = 2'd0;
    step();
    check("t6_rs_addr", imem_addr, 8'h10);
    check("t6_rs_req", {7'd0, imem_req}, 8'h01);
    step();
    check("t6_rs_pc", PC, 8'h10);
    check("t6_rs_inst", inst, 8'hB5);
    check("t6_rs_stall", {7'd0, stall}, 8'h01);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
